// File: rtl/life_round_if.sv
// Cell-RAM port bundle for the Game-of-Life engine: one source read port
// and one destination write port, both with packed {y, x} addresses.
interface life_round_if #(
  parameter int P_W = 12
);
  logic [2*P_W-1:0] round_read_pos;
  logic             prev_status;
  logic [2*P_W-1:0] round_write_pos;
  logic             wden;
  logic             live;

  modport master (
    output round_read_pos,
    input  prev_status,
    output round_write_pos,
    output wden,
    output live
  );

  modport slave (
    input  round_read_pos,
    output prev_status,
    input  round_write_pos,
    input  wden,
    input  live
  );
endinterface

// File: rtl/life_round.sv
// B3/S23 generation engine: each level change of global_evo_en runs one
// row-major pass, 11 cycles per cell (9 reads, 1 trailing sample, 1 write).
//
// state | meaning
// IDLE  | waiting for a toggle of global_evo_en, busy low
// READ  | issuing neighbour read k = 0..8, sampling k-1
// LAST  | sampling neighbour k = 8
// WRITE | strobing wden with the new state of the current cell
module life_round #(
  parameter int P_M = 300,
  parameter int P_N = 400,
  parameter int P_W = 12
) (
  input  logic       clk_vga,
  input  logic       reset_btn,
  input  logic       global_evo_en,
  output logic       busy,
  life_round_if.master ram
);

  typedef enum logic [1:0] {IDLE, READ, LAST, WRITE} state_t;

  localparam logic [P_W-1:0] Y_MAX = P_W'(P_M - 1);
  localparam logic [P_W-1:0] X_MAX = P_W'(P_N - 1);
  localparam logic [P_W-1:0] ONE   = P_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [P_W-1:0]   y_q, y_d, x_q, x_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ctr_q, ctr_d;
  logic             en_q;
  logic [2*P_W-1:0] rd_pos_q, rd_pos_d;
  logic [2*P_W-1:0] wr_pos_q, wr_pos_d;

  logic             edge_det;
  logic             sample_en;
  logic [3:0]       k_smp;
  logic             smp_bit;
  logic [2*P_W:0]   smp_nbr;
  logic [2*P_W:0]   rd_nbr;

  // Returns {out_of_range, address}; out-of-range neighbours map to the centre.
  function automatic logic [2*P_W:0] nbr(input logic [3:0] k,
                                         input logic [P_W-1:0] y,
                                         input logic [P_W-1:0] x);
    logic [P_W-1:0] ny;
    logic [P_W-1:0] nx;
    logic           oob;
    ny  = y;
    nx  = x;
    oob = 1'b0;
    case (k)
      4'd0, 4'd1, 4'd2: if (y == '0) oob = 1'b1; else ny = y - ONE;
      4'd6, 4'd7, 4'd8: if (y == Y_MAX) oob = 1'b1; else ny = y + ONE;
      default: ;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: if (x == '0) oob = 1'b1; else nx = x - ONE;
      4'd2, 4'd5, 4'd8: if (x == X_MAX) oob = 1'b1; else nx = x + ONE;
      default: ;
    endcase
    return oob ? {1'b1, y, x} : {1'b0, ny, nx};
  endfunction

  assign edge_det = (global_evo_en != en_q);

  // Data on prev_status belongs to the read issued in the previous cycle.
  assign k_smp   = (state_q == LAST) ? 4'd8 : (k_q - 4'd1);
  assign smp_nbr = nbr(k_smp, y_q, x_q);
  assign smp_bit = ram.prev_status & ~smp_nbr[2*P_W];
  assign rd_nbr  = nbr(k_d, y_d, x_d);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    y_d       = y_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    ctr_d     = ctr_q;
    wr_pos_d  = wr_pos_q;
    sample_en = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        ctr_d = 1'b0;
        if (edge_det) begin
          state_d = READ;
          k_d     = '0;
          y_d     = '0;
          x_d     = '0;
        end
      end
      READ: begin
        sample_en = (k_q != 4'd0);
        if (k_q == 4'd8) state_d = LAST;
        else             k_d     = k_q + 4'd1;
      end
      LAST: begin
        sample_en = 1'b1;
        state_d   = WRITE;
        wr_pos_d  = {y_q, x_q};
      end
      WRITE: begin
        cnt_d = '0;
        ctr_d = 1'b0;
        k_d   = '0;
        if (x_q == X_MAX) begin
          x_d = '0;
          if (y_q == Y_MAX) begin
            state_d = IDLE;
          end else begin
            y_d     = y_q + ONE;
            state_d = READ;
          end
        end else begin
          x_d     = x_q + ONE;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sample_en) begin
      if (k_smp == 4'd4) ctr_d = smp_bit;
      else               cnt_d = cnt_q + {3'b000, smp_bit};
    end

    rd_pos_d = (state_d == READ) ? rd_nbr[2*P_W-1:0] : rd_pos_q;
  end

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_q  <= IDLE;
      k_q      <= '0;
      y_q      <= '0;
      x_q      <= '0;
      cnt_q    <= '0;
      ctr_q    <= 1'b0;
      en_q     <= 1'b0;
      rd_pos_q <= '0;
      wr_pos_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      y_q      <= y_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      ctr_q    <= ctr_d;
      en_q     <= global_evo_en;
      rd_pos_q <= rd_pos_d;
      wr_pos_q <= wr_pos_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign ram.wden            = (state_q == WRITE);
  assign ram.live            = ram.wden & ((cnt_q == 4'd3) | (ctr_q & (cnt_q == 4'd2)));
  assign ram.round_read_pos  = rd_pos_q;
  assign ram.round_write_pos = wr_pos_q;

endmodule

// File: tb/tb_life_round.sv
// Bench for life_round on a reduced grid: a behavioural RAM and a direct
// B3/S23 neighbour-count model judge every pass, its timing and reset abort.
module tb_life_round;
  localparam int M     = 6;
  localparam int N     = 7;
  localparam int W     = 12;
  localparam int CELLS = M * N;
  localparam int PASS  = 11 * CELLS;

  logic clk_vga = 1'b0;
  logic reset_btn;
  logic global_evo_en;
  logic busy;

  life_round_if #(.P_W(W)) ram_if ();

  life_round #(.P_M(M), .P_N(N), .P_W(W)) dut (
    .clk_vga       (clk_vga),
    .reset_btn     (reset_btn),
    .global_evo_en (global_evo_en),
    .busy          (busy),
    .ram           (ram_if)
  );

  always #10 clk_vga = ~clk_vga;

  bit          src   [M][N];
  bit          dst   [M][N];
  bit          exp_g [M][N];
  int          wcyc  [CELLS];
  logic [23:0] wpos  [CELLS];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int e_cyc, wcnt, stray, oobrd, rise_cyc, fall_cyc;
  bit busy_prev = 1'b0;
  bit lvl;

  always @(posedge clk_vga) cyc <= cyc + 1;

  // Source RAM with one-cycle synchronous read.
  always @(posedge clk_vga) begin
    int ry, rx;
    ry = int'(ram_if.round_read_pos[2*W-1:W]);
    rx = int'(ram_if.round_read_pos[W-1:0]);
    if (ry < M && rx < N) ram_if.prev_status <= src[ry][rx];
    else                  ram_if.prev_status <= 1'b0;
  end

  always @(negedge clk_vga) begin
    int wy, wx, ry, rx;
    if (ram_if.wden) begin
      if (wcnt < CELLS) begin
        wcyc[wcnt] = cyc;
        wpos[wcnt] = ram_if.round_write_pos;
      end
      wy = int'(ram_if.round_write_pos[2*W-1:W]);
      wx = int'(ram_if.round_write_pos[W-1:0]);
      if (wy < M && wx < N) dst[wy][wx] = ram_if.live;
      wcnt++;
    end else if (ram_if.live) begin
      stray++;
    end
    ry = int'(ram_if.round_read_pos[2*W-1:W]);
    rx = int'(ram_if.round_read_pos[W-1:0]);
    if (busy && (ry >= M || rx >= N)) oobrd++;
    if (busy && !busy_prev) rise_cyc = cyc;
    if (!busy && busy_prev) fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model();
    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dy == 0 && dx == 0) && y+dy >= 0 && y+dy < M && x+dx >= 0 && x+dx < N)
              n += int'(src[y+dy][x+dx]);
        exp_g[y][x] = (n == 3) || (src[y][x] && n == 2);
      end
  endfunction

  task automatic clear_src();
    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++) src[y][x] = 1'b0;
  endtask

  task automatic start_pass();
    model();
    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++) dst[y][x] = ~exp_g[y][x];
    for (int i = 0; i < CELLS; i++) begin
      wcyc[i] = -1;
      wpos[i] = '1;
    end
    wcnt = 0; stray = 0; oobrd = 0; rise_cyc = -1; fall_cyc = -1;
    @(posedge clk_vga); #1;
    lvl = ~lvl;
    global_evo_en = lvl;
    e_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < PASS + 40; i++) begin
      @(posedge clk_vga); #1;
      if (fall_cyc >= 0) break;
    end
    chk({tag, " done_in_budget"}, 32'(fall_cyc >= 0), 1);
  endtask

  task automatic check_pass(input string tag);
    int bad;
    logic [23:0] ep;
    bad = 0;
    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++)
        if (dst[y][x] != exp_g[y][x]) bad++;
    chk({tag, " grid"}, bad, 0);
    chk({tag, " writes"}, wcnt, CELLS);
    chk({tag, " stray_live"}, stray, 0);
    chk({tag, " oob_read"}, oobrd, 0);
    chk({tag, " busy_rise"}, rise_cyc, e_cyc + 1);
    chk({tag, " busy_fall"}, fall_cyc, e_cyc + PASS + 1);
    bad = 0;
    for (int n = 0; n < CELLS; n++) begin
      ep = {W'(n / N), W'(n % N)};
      if (wcyc[n] != e_cyc + 11 + 11*n || wpos[n] !== ep) bad++;
    end
    chk({tag, " wr_sched"}, bad, 0);
  endtask

  task automatic rule_pass(input string tag, input bit exp_ctr);
    start_pass();
    wait_done(tag);
    check_pass(tag);
    chk({tag, " centre"}, 32'(dst[2][3]), 32'(exp_ctr));
  endtask

  initial begin
    int ones;
    reset_btn     = 1'b1;
    global_evo_en = 1'b0;
    lvl           = 1'b0;
    wcnt = 0; stray = 0; oobrd = 0; rise_cyc = -1; fall_cyc = -1;
    clear_src();
    repeat (3) @(posedge clk_vga);
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst wden", 32'(ram_if.wden), 0);
    chk("rst live", 32'(ram_if.live), 0);
    chk("rst rd_pos", 32'(ram_if.round_read_pos), 0);
    chk("rst wr_pos", 32'(ram_if.round_write_pos), 0);
    reset_btn = 1'b0;
    repeat (5) @(posedge clk_vga);

    // Blinker, rising edge, with explicit schedule points
    clear_src();
    src[2][2] = 1'b1; src[2][3] = 1'b1; src[2][4] = 1'b1;
    start_pass();
    wait_done("blinker");
    check_pass("blinker");
    chk("first_wr_cyc", wcyc[0], e_cyc + 11);
    chk("first_wr_pos", 32'(wpos[0]), 0);
    chk("second_wr_cyc", wcyc[1], e_cyc + 22);
    chk("second_wr_pos", 32'(wpos[1]), 1);
    chk("row1_wr_cyc", wcyc[N], e_cyc + 11*(N+1));
    chk("row1_wr_pos", 32'(wpos[N]), 32'h001000);
    ones = 0;
    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++) ones += int'(dst[y][x]);
    chk("blinker ones", ones, 3);
    chk("blinker vertical", 32'({dst[1][3], dst[2][3], dst[3][3]}), 32'b111);

    // Corner block on a falling edge; a toggle while busy must be ignored
    clear_src();
    src[0][0] = 1'b1; src[0][1] = 1'b1; src[1][0] = 1'b1; src[1][1] = 1'b1;
    start_pass();
    chk("fall_edge lvl", 32'(global_evo_en), 0);
    repeat (100) @(posedge clk_vga);
    #1;
    lvl = ~lvl;
    global_evo_en = lvl;
    wait_done("corner");
    check_pass("corner");
    chk("corner block", 32'({dst[0][0], dst[0][1], dst[1][0], dst[1][1]}), 32'b1111);
    repeat (PASS / 2) @(posedge clk_vga);
    #1;
    chk("no_extra_pass writes", wcnt, CELLS);
    chk("no_extra_pass busy", 32'(busy), 0);

    // Isolated 3x3 rule patterns around centre (2,3)
    clear_src();
    src[1][2] = 1'b1; src[1][3] = 1'b1; src[1][4] = 1'b1;
    rule_pass("dead+3", 1'b1);
    clear_src();
    src[2][3] = 1'b1; src[1][2] = 1'b1; src[3][4] = 1'b1;
    rule_pass("live+2", 1'b1);
    clear_src();
    src[2][3] = 1'b1; src[1][2] = 1'b1;
    rule_pass("live+1", 1'b0);
    clear_src();
    src[2][3] = 1'b1; src[1][2] = 1'b1; src[1][4] = 1'b1; src[3][2] = 1'b1; src[3][4] = 1'b1;
    rule_pass("live+4", 1'b0);

    // Random grids
    for (int r = 0; r < 3; r++) begin
      for (int y = 0; y < M; y++)
        for (int x = 0; x < N; x++) src[y][x] = ($urandom_range(0, 99) < 40);
      start_pass();
      wait_done("random");
      check_pass("random");
    end

    // Reset in the middle of a pass, landing on the write of cell 17
    start_pass();
    repeat (11 * 18) @(posedge clk_vga);
    #3;
    chk("pre_rst wden", 32'(ram_if.wden), 1);
    reset_btn     = 1'b1;
    global_evo_en = 1'b0;
    lvl           = 1'b0;
    #1;
    chk("mid_rst busy", 32'(busy), 0);
    chk("mid_rst wden", 32'(ram_if.wden), 0);
    chk("mid_rst live", 32'(ram_if.live), 0);
    repeat (3) @(posedge clk_vga);
    #1;
    reset_btn = 1'b0;
    wcnt = 0;
    repeat (PASS + 20) @(posedge clk_vga);
    #1;
    chk("post_rst writes", wcnt, 0);
    chk("post_rst busy", 32'(busy), 0);

    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++) src[y][x] = ($urandom_range(0, 99) < 50);
    start_pass();
    wait_done("after_rst");
    check_pass("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
